// File: rtl/mux2x2_arb_pkg.sv
// Shared types and constants for the two-source mux arbiter.
// State encoding is fixed so that parent-level debug taps can decode it.
package mux2x2_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  // Ownership state for a given source index.
  function automatic state_t own_state(input logic src);
    return (src == SRC1) ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/mux2x2_arb_cnt.sv
// Burst transfer counter: synchronous clear beats increment; tc flags the
// last transfer slot of a burst (count == BURST-1).
module mux2x2_arb_cnt #(
  parameter int BURST = 4,
  parameter int CNTW  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [CNTW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tc = (cnt_reg == CNTW'(BURST - 1));

endmodule

// File: rtl/mux2x2_arb.sv
// Two-source burst arbiter driving a shared registered 2:1 mux (S, CE) and
// tracking the word held in the mux register. Define MUX2X2_ARB_FIXED_PRI_EN
// for strict source-0 priority instead of round-robin.
module mux2x2_arb
  import mux2x2_arb_pkg::*;
#(
  parameter int BURST = 4,
  parameter int CNTW  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic s,
  output logic ce,
  output logic qv,
  output logic qsrc
);

  state_t     state_reg, state_next;
  logic       qv_reg, qsrc_reg;
  logic [1:0] req, gnt, xfer;
  logic       cur_src, cur_req;
  logic       cnt_clr, cnt_inc, cnt_tc;
`ifndef MUX2X2_ARB_FIXED_PRI_EN
  logic       last_reg, last_next;
  logic       oth_req;
`endif

  assign req = {req1, req0};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign gnt[gi]  = (state_reg == own_state(1'(gi)));
      assign xfer[gi] = gnt[gi] & req[gi];
    end
  endgenerate

  assign gnt0 = gnt[SRC0];
  assign gnt1 = gnt[SRC1];
  assign s    = (state_reg == ST_OWN1);
  assign ce   = |xfer;
  assign qv   = qv_reg;
  assign qsrc = qsrc_reg;

  mux2x2_arb_cnt #(
    .BURST (BURST),
    .CNTW  (CNTW)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .tc  (cnt_tc)
  );

  always_comb begin
    state_next = state_reg;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    cur_src    = (state_reg == ST_OWN1);
    cur_req    = req[cur_src];
`ifndef MUX2X2_ARB_FIXED_PRI_EN
    oth_req    = req[~cur_src];
    last_next  = last_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (req0 && req1) begin
`ifdef MUX2X2_ARB_FIXED_PRI_EN
          state_next = ST_OWN0;
`else
          state_next = own_state(~last_reg);
`endif
        end else if (req0) begin
          state_next = ST_OWN0;
        end else if (req1) begin
          state_next = ST_OWN1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        // A dropped request is a release, even on the terminal count slot.
        if (!cur_req || cnt_tc) begin
          cnt_clr = 1'b1;
`ifdef MUX2X2_ARB_FIXED_PRI_EN
          if (req[SRC0]) begin
            state_next = ST_OWN0;
          end else if (req[SRC1]) begin
            state_next = ST_OWN1;
          end else begin
            state_next = ST_IDLE;
          end
`else
          if (oth_req) begin
            state_next = own_state(~cur_src);
          end else if (cur_req) begin
            state_next = own_state(cur_src);
          end else begin
            state_next = ST_IDLE;
          end
`endif
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_clr    = 1'b1;
      end
    endcase
`ifndef MUX2X2_ARB_FIXED_PRI_EN
    if (state_next == ST_OWN0) begin
      last_next = SRC0;
    end else if (state_next == ST_OWN1) begin
      last_next = SRC1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      qv_reg    <= 1'b0;
      qsrc_reg  <= SRC0;
    end else begin
      state_reg <= state_next;
      qv_reg    <= ce;
      qsrc_reg  <= s;
    end
  end

`ifndef MUX2X2_ARB_FIXED_PRI_EN
  // Reset to source 1 so that source 0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_reg <= SRC1;
    end else begin
      last_reg <= last_next;
    end
  end
`endif

endmodule

// File: tb/tb_mux2x2_arb.sv
// Scoreboard bench for mux2x2_arb: a BURST=4 and a BURST=1 instance share
// inputs; each row names which instance(s) it checks. Honours MUX2X2_ARB_FIXED_PRI_EN.
module tb_mux2x2_arb;

  typedef struct {
    string      tag;
    int         row;
    logic [1:0] mask;
    logic [5:0] exp;
  } exp_t;

  localparam logic [1:0] M4 = 2'b01;
  localparam logic [1:0] M1 = 2'b10;
  localparam logic [1:0] MB = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req0 = 1'b0;
  logic req1 = 1'b0;
  logic gnt0_4, gnt1_4, s_4, ce_4, qv_4, qsrc_4;
  logic gnt0_1, gnt1_1, s_1, ce_1, qv_1, qsrc_1;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   row_id = 0;

  always #5 clk = ~clk;

  mux2x2_arb #(.BURST(4), .CNTW(8)) dut4 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .gnt0(gnt0_4), .gnt1(gnt1_4), .s(s_4), .ce(ce_4), .qv(qv_4), .qsrc(qsrc_4)
  );

  mux2x2_arb #(.BURST(1), .CNTW(8)) dut1 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .gnt0(gnt0_1), .gnt1(gnt1_1), .s(s_1), .ce(ce_1), .qv(qv_1), .qsrc(qsrc_1)
  );

  // Drive one cycle of inputs just after the rising edge and queue the
  // outputs {gnt0,gnt1,s,ce,qv,qsrc} expected during that cycle.
  task automatic cyc(input logic r, input logic a, input logic b,
                     input logic [1:0] m, input logic [5:0] e, input string tag);
    exp_t x;
    @(posedge clk);
    #1;
    rst  = r;
    req0 = a;
    req1 = b;
    x.tag  = tag;
    x.row  = row_id;
    x.mask = m;
    x.exp  = e;
    row_id++;
    sb.push_back(x);
  endtask

  // Monitor: compares at the falling edge, decoupled from stimulus.
  initial begin
    exp_t       x;
    logic [5:0] a4, a1;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x  = sb.pop_front();
        a4 = {gnt0_4, gnt1_4, s_4, ce_4, qv_4, qsrc_4};
        a1 = {gnt0_1, gnt1_1, s_1, ce_1, qv_1, qsrc_1};
        if (x.mask[0]) begin
          n_cmp++;
          if (a4 !== x.exp) begin
            n_bad++;
            $display("FAIL %s row %0d burst4: got %b want %b (g0 g1 s ce qv qsrc)",
                     x.tag, x.row, a4, x.exp);
          end
        end
        if (x.mask[1]) begin
          n_cmp++;
          if (a1 !== x.exp) begin
            n_bad++;
            $display("FAIL %s row %0d burst1: got %b want %b (g0 g1 s ce qv qsrc)",
                     x.tag, x.row, a1, x.exp);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] both4 [13];
    logic [5:0] b1 [5];

    // Reset held, then a single requester for 10 cycles.
    cyc(0, 1, 0, MB, 6'b000000, "rst_hold");
    cyc(1, 1, 0, M4, 6'b000000, "rst_release");
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 0, M4, (i == 0) ? 6'b100100 : 6'b100110, "single");
    end

    // Reset two transfers into a burst; the burst restarts from zero.
    cyc(0, 1, 0, MB, 6'b000000, "rst_mid");
    cyc(1, 1, 0, M4, 6'b000000, "rst_mid_rel");
    cyc(1, 1, 0, M4, 6'b100100, "regrant");
    cyc(1, 1, 0, M4, 6'b100110, "regrant");
    cyc(1, 1, 0, M4, 6'b100110, "regrant");
    cyc(1, 1, 1, M4, 6'b100110, "burst_end");
`ifdef MUX2X2_ARB_FIXED_PRI_EN
    cyc(1, 0, 0, M4, 6'b100010, "after_end");
    cyc(1, 0, 0, M4, 6'b000000, "idle");
`else
    cyc(1, 0, 0, M4, 6'b011010, "after_end");
    cyc(1, 0, 0, M4, 6'b000001, "idle");
`endif

    // Early release of source 0 while source 1 waits.
    cyc(0, 0, 0, MB, 6'b000000, "rst2");
    cyc(1, 1, 0, M4, 6'b000000, "early_idle");
    cyc(1, 1, 1, M4, 6'b100100, "early_own0");
    cyc(1, 1, 1, M4, 6'b100110, "early_own0");
    cyc(1, 0, 1, M4, 6'b100010, "early_drop");
    cyc(1, 0, 1, M4, 6'b011100, "early_own1");
    cyc(1, 0, 1, M4, 6'b011111, "early_own1");
    cyc(1, 0, 0, M4, 6'b011011, "early_rel1");
    cyc(1, 0, 0, M4, 6'b000001, "early_idle2");

    // Both sources requesting continuously, BURST=4.
`ifdef MUX2X2_ARB_FIXED_PRI_EN
    both4 = '{6'b100100, 6'b100110, 6'b100110, 6'b100110, 6'b100110,
              6'b100110, 6'b100110, 6'b100110, 6'b100110, 6'b100110,
              6'b100110, 6'b100110, 6'b100110};
`else
    both4 = '{6'b100100, 6'b100110, 6'b100110, 6'b100110, 6'b011110,
              6'b011111, 6'b011111, 6'b011111, 6'b100111, 6'b100110,
              6'b100110, 6'b100110, 6'b011110};
`endif
    cyc(0, 0, 0, MB, 6'b000000, "rst3");
    cyc(1, 1, 1, M4, 6'b000000, "both_idle");
    for (int i = 0; i < 13; i++) begin
      cyc(1, 1, 1, M4, both4[i], "both");
    end
`ifdef MUX2X2_ARB_FIXED_PRI_EN
    cyc(1, 0, 1, M4, 6'b100010, "req0_drop");
    cyc(1, 0, 1, M4, 6'b011100, "req0_drop");
`else
    cyc(1, 0, 1, M4, 6'b011111, "req0_drop");
    cyc(1, 0, 1, M4, 6'b011111, "req0_drop");
`endif
    cyc(1, 0, 0, M4, 6'b011011, "both_rel");
    cyc(1, 0, 0, M4, 6'b000001, "both_done");

    // BURST=1 instance, both requesting.
`ifdef MUX2X2_ARB_FIXED_PRI_EN
    b1 = '{6'b100100, 6'b100110, 6'b100110, 6'b100110, 6'b100110};
`else
    b1 = '{6'b100100, 6'b011110, 6'b100111, 6'b011110, 6'b100111};
`endif
    cyc(0, 0, 0, MB, 6'b000000, "rst4");
    cyc(1, 1, 1, M1, 6'b000000, "b1_idle");
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 1, M1, b1[i], "b1_alt");
    end
`ifdef MUX2X2_ARB_FIXED_PRI_EN
    cyc(1, 0, 0, M1, 6'b100010, "b1_rel");
    cyc(1, 0, 0, M1, 6'b000000, "b1_done");
`else
    cyc(1, 0, 0, M1, 6'b011010, "b1_rel");
    cyc(1, 0, 0, M1, 6'b000001, "b1_done");
`endif

    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d rows left unchecked, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
